// File: rtl/scale_pkg.sv
// Shared constants for the target-raster coordinate generator.
//   DW    : width of dimension, counter and coordinate fields
//   KW    : width of the Q8.8 scale factors
//   FRAC  : fraction bits in a scale factor (K_UNITY means 1:1)
//   ACCW  : accumulator width, wide enough for 2047 steps of the largest k
//   ST_*  : FSM state encoding
package scale_pkg;
  localparam int DW      = 11;
  localparam int KW      = 16;
  localparam int FRAC    = 8;
  localparam int ACCW    = DW + KW;
  localparam int K_UNITY = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/scale_axis_acc.sv
// One axis of the coordinate generator: a DDA accumulator in Q(DW+8).8 plus
// the registered, clamped integer coordinate and fraction of the current beat.
// Ports:
//   clk_wr, rst : write-domain clock, synchronous active-high reset
//   clr         : zero the accumulator and outputs (frame load / line start)
//   en          : advance the accumulator by k and register the new mapping
//   k           : step size, Q8.8
//   lim         : source extent; coordinates clamp to lim-1 (lim 0 clamps to 0)
//   coord, frac : registered source coordinate and interpolation fraction
module scale_axis_acc
  import scale_pkg::*;
(
  input  logic            clk_wr,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [KW-1:0]   k,
  input  logic [DW-1:0]   lim,
  output logic [DW-1:0]   coord,
  output logic [FRAC-1:0] frac
);

  logic [ACCW-1:0]      acc;
  logic [ACCW-1:0]      acc_sum;
  logic [DW+FRAC-1:0]   sat_sum;

  // Clamp the integer part to lim-1; a clamped coordinate carries no fraction
  // because interpolating past the last source sample is meaningless.
  function automatic logic [DW+FRAC-1:0] sat_coord(input logic [ACCW-1:0] a,
                                                   input logic [DW-1:0]   l);
    logic [ACCW-FRAC-1:0] ip;
    ip = a[ACCW-1:FRAC];
    if (l == '0)
      sat_coord = '0;
    else if (ip > (ACCW-FRAC)'(l - DW'(1)))
      sat_coord = {l - DW'(1), FRAC'(0)};
    else
      sat_coord = {ip[DW-1:0], a[FRAC-1:0]};
  endfunction

  assign acc_sum = acc + ACCW'(k);
  assign sat_sum = sat_coord(acc_sum, lim);

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      acc   <= '0;
      coord <= '0;
      frac  <= '0;
    end else if (clr) begin
      acc   <= '0;
      coord <= '0;
      frac  <= '0;
    end else if (en) begin
      acc           <= acc_sum;
      {coord, frac} <= sat_sum;
    end
  end

endmodule

// File: rtl/scale_coord_gen.sv
// Target-raster coordinate generator for the video scaler datapath.
// For every target pixel of a frame it presents the clamped source (x,y)
// coordinate and 8-bit interpolation fractions under valid/ready.
// Ports:
//   clk_wr, rst            : write-domain clock, synchronous active-high reset
//   frame_start            : one-cycle pulse, starts (or restarts) a frame
//   t_width, t_height      : target raster size
//   s_width, s_height      : source raster size, used for clamping
//   h_scale_k, v_scale_k   : Q8.8 steps, source*256/target
//   coord_ready            : downstream accepts the presented beat
//   coord_valid            : beat valid
//   src_x/src_y, frac_x/frac_y : source coordinate and fractions
//   line_last, frame_last  : last beat of line / frame
//   busy                   : FSM not idle
//   frame_done             : pulse once the last beat has been accepted
//   restart_err            : pulse when frame_start aborts a running frame
module scale_coord_gen
  import scale_pkg::*;
(
  input  logic            clk_wr,
  input  logic            rst,
  input  logic            frame_start,
  input  logic [DW-1:0]   t_width,
  input  logic [DW-1:0]   t_height,
  input  logic [DW-1:0]   s_width,
  input  logic [DW-1:0]   s_height,
  input  logic [KW-1:0]   h_scale_k,
  input  logic [KW-1:0]   v_scale_k,
  input  logic            coord_ready,
  output logic            coord_valid,
  output logic [DW-1:0]   src_x,
  output logic [DW-1:0]   src_y,
  output logic [FRAC-1:0] frac_x,
  output logic [FRAC-1:0] frac_y,
  output logic            line_last,
  output logic            frame_last,
  output logic            busy,
  output logic            frame_done,
  output logic            restart_err
);

  logic [1:0]    state, state_n;
  logic [DW-1:0] sh_tw, sh_th, sh_sw, sh_sh;
  logic [KW-1:0] sh_hk, sh_vk;
  logic [DW-1:0] tx, ty;
  logic [DW-1:0] tw_m1, th_m1, tx_inc, ty_inc;
  logic          dims_ok, accept, step;
  logic          x_clr, x_en, y_clr, y_en;

  assign tw_m1   = sh_tw - DW'(1);
  assign th_m1   = sh_th - DW'(1);
  assign tx_inc  = tx + DW'(1);
  assign ty_inc  = ty + DW'(1);
  assign dims_ok = (sh_tw != '0) && (sh_th != '0);
  assign accept  = coord_valid && coord_ready;
  // A frame_start on the same edge withdraws the pending beat, so it never
  // counts as consumed even when coord_ready is high.
  assign step    = accept && !frame_start;

  always_comb begin
    state_n = state;
    if (frame_start) begin
      state_n = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_IDLE;
        ST_LOAD: state_n = dims_ok ? ST_RUN : ST_IDLE;
        ST_RUN:  if (step && frame_last) state_n = ST_DONE;
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Frame parameters are captured on frame_start and held for the frame.
  always_ff @(posedge clk_wr) begin
    if (frame_start) begin
      sh_tw <= t_width;
      sh_th <= t_height;
      sh_sw <= s_width;
      sh_sh <= s_height;
      sh_hk <= h_scale_k;
      sh_vk <= v_scale_k;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      coord_valid <= 1'b0;
      line_last   <= 1'b0;
      frame_last  <= 1'b0;
      frame_done  <= 1'b0;
      restart_err <= 1'b0;
      tx          <= '0;
      ty          <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != ST_IDLE);
      frame_done  <= 1'b0;
      restart_err <= 1'b0;
      if (frame_start) begin
        coord_valid <= 1'b0;
        line_last   <= 1'b0;
        frame_last  <= 1'b0;
        restart_err <= (state == ST_RUN) || (state == ST_DONE);
      end else begin
        case (state)
          ST_LOAD: begin
            tx <= '0;
            ty <= '0;
            if (dims_ok) begin
              coord_valid <= 1'b1;
              line_last   <= (tw_m1 == '0);
              frame_last  <= (tw_m1 == '0) && (th_m1 == '0);
            end else begin
              frame_done  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (accept) begin
              if (frame_last) begin
                coord_valid <= 1'b0;
                line_last   <= 1'b0;
                frame_last  <= 1'b0;
                frame_done  <= 1'b1;
              end else if (line_last) begin
                tx         <= '0;
                ty         <= ty_inc;
                line_last  <= (tw_m1 == '0);
                frame_last <= (tw_m1 == '0) && (ty_inc == th_m1);
              end else begin
                tx         <= tx_inc;
                line_last  <= (tx_inc == tw_m1);
                frame_last <= (tx_inc == tw_m1) && (ty == th_m1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // x restarts at every line start; y advances once per completed line.
  assign x_clr = (state == ST_LOAD) || (step && line_last);
  assign x_en  = step && !line_last;
  assign y_clr = (state == ST_LOAD);
  assign y_en  = step && line_last;

  scale_axis_acc u_axis_x (
    .clk_wr (clk_wr),
    .rst    (rst),
    .clr    (x_clr),
    .en     (x_en),
    .k      (sh_hk),
    .lim    (sh_sw),
    .coord  (src_x),
    .frac   (frac_x)
  );

  scale_axis_acc u_axis_y (
    .clk_wr (clk_wr),
    .rst    (rst),
    .clr    (y_clr),
    .en     (y_en),
    .k      (sh_vk),
    .lim    (sh_sh),
    .coord  (src_y),
    .frac   (frac_y)
  );

endmodule

// File: tb/tb_scale_coord_gen.sv
// Scoreboard bench for scale_coord_gen: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every accepted beat.
module tb_scale_coord_gen;
  import scale_pkg::*;

  logic            clk_wr = 1'b0;
  logic            rst, frame_start, coord_ready;
  logic [DW-1:0]   t_width, t_height, s_width, s_height;
  logic [KW-1:0]   h_scale_k, v_scale_k;
  logic            coord_valid, line_last, frame_last, busy, frame_done, restart_err;
  logic [DW-1:0]   src_x, src_y;
  logic [FRAC-1:0] frac_x, frac_y;

  always #5 clk_wr = ~clk_wr;

  scale_coord_gen dut (
    .clk_wr      (clk_wr),
    .rst         (rst),
    .frame_start (frame_start),
    .t_width     (t_width),
    .t_height    (t_height),
    .s_width     (s_width),
    .s_height    (s_height),
    .h_scale_k   (h_scale_k),
    .v_scale_k   (v_scale_k),
    .coord_ready (coord_ready),
    .coord_valid (coord_valid),
    .src_x       (src_x),
    .src_y       (src_y),
    .frac_x      (frac_x),
    .frac_y      (frac_y),
    .line_last   (line_last),
    .frame_last  (frame_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .restart_err (restart_err)
  );

  typedef struct packed {
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic [FRAC-1:0] fx;
    logic [FRAC-1:0] fy;
    logic            ll;
    logic            fl;
  } beat_t;

  beat_t exp_q[$];
  beat_t last_beat, held;
  logic  stall_prev = 1'b0;
  int    n_chk = 0, n_fail = 0;
  int    n_beats = 0, n_done = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b = {src_x, src_y, frac_x, frac_y, line_last, frame_last};
    return b;
  endfunction

  // Reference mapping written from the output definition: coordinate of
  // target pixel t is (t*k)/256 with clamping to lim-1 and no fraction there.
  function automatic logic [DW+FRAC-1:0] ref_map(input int a, input int lim);
    int ip;
    ip = a / 256;
    if (lim == 0) return '0;
    if (ip >= lim) return {DW'(lim - 1), FRAC'(0)};
    return {DW'(ip), FRAC'(a % 256)};
  endfunction

  task automatic push_model(input int tw, th, sw, sh, hk, vk);
    beat_t e;
    for (int y = 0; y < th; y++) begin
      for (int x = 0; x < tw; x++) begin
        {e.x, e.fx} = ref_map(x * hk, sw);
        {e.y, e.fy} = ref_map(y * vk, sh);
        e.ll = (x == tw - 1);
        e.fl = (x == tw - 1) && (y == th - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_b(input int x, y, fx, fy, input bit ll, fl);
    beat_t e;
    e = {DW'(x), DW'(y), FRAC'(fx), FRAC'(fy), ll, fl};
    exp_q.push_back(e);
  endtask

  // Leaves the bench one cycle into LOAD (just after the edge that sampled
  // frame_start).
  task automatic start_frame(input int tw, th, sw, sh, hk, vk);
    @(posedge clk_wr); #1;
    t_width   = DW'(tw);
    t_height  = DW'(th);
    s_width   = DW'(sw);
    s_height  = DW'(sh);
    h_scale_k = KW'(hk);
    v_scale_k = KW'(vk);
    frame_start = 1'b1;
    @(posedge clk_wr); #1;
    frame_start = 1'b0;
  endtask

  // rnd=1: random coord_ready with a 10-cycle stall early in the frame.
  task automatic wait_done(input int budget, input bit rnd, input string nm);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      if (rnd) coord_ready = (c >= 3 && c < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      else     coord_ready = 1'b1;
      @(posedge clk_wr); #1;
      if (frame_done) got = 1'b1;
    end
    coord_ready = 1'b1;
    @(posedge clk_wr); #1;
    chk({nm, "_frame_done"}, 64'(got), 64'd1);
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk_wr) begin
    beat_t b, e;
    b = cur_beat();
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_hold", 64'(coord_valid), 64'd1);
        chk("stall_fields_hold", 64'(b), 64'(held));
      end
      if (coord_valid && coord_ready && !frame_start) begin
        n_beats++;
        last_beat = b;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat: got unexpected beat 0x%0h, expected no beat", b);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(b), 64'(e));
        end
      end
      stall_prev = coord_valid && !coord_ready && !frame_start;
      held = b;
      if (frame_done)  n_done++;
      if (restart_err) n_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, e0, b0;
    rst = 1'b1; frame_start = 1'b0; coord_ready = 1'b1;
    t_width = '0; t_height = '0; s_width = '0; s_height = '0;
    h_scale_k = '0; v_scale_k = '0;
    repeat (3) @(posedge clk_wr);
    #1;
    chk("rst_valid", 64'(coord_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_restart_err", 64'(restart_err), 64'd0);
    chk("rst_fields", 64'(cur_beat()), 64'd0);
    rst = 1'b0;

    // 1:1 mapping, 4x2, with latency checks
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        push_b(x, y, 0, 0, x == 3, (x == 3) && (y == 1));
    start_frame(4, 2, 4, 2, 256, 256);
    chk("lat_load_valid", 64'(coord_valid), 64'd0);
    chk("lat_load_busy", 64'(busy), 64'd1);
    @(posedge clk_wr); #1;
    chk("lat_first_valid", 64'(coord_valid), 64'd1);
    wait_done(40, 1'b0, "unity");
    chk("unity_beats", 64'(n_beats), 64'd8);
    chk("unity_done_cnt", 64'(n_done), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // 2x upscale: x = 0,0,1,1 with fractions 0,128,0,128
    push_b(0, 0, 0,   0, 1'b0, 1'b0);
    push_b(0, 0, 128, 0, 1'b0, 1'b0);
    push_b(1, 0, 0,   0, 1'b0, 1'b0);
    push_b(1, 0, 128, 0, 1'b1, 1'b1);
    start_frame(4, 1, 2, 1, 128, 256);
    wait_done(40, 1'b0, "upscale");

    // Production ratio 720->1024: last pixel 1023*180 = 719*256 + 76
    push_model(1024, 1, 720, 4, 180, 256);
    start_frame(1024, 1, 720, 4, 180, 256);
    wait_done(1100, 1'b0, "clamp720");
    chk("clamp720_last_x", 64'(last_beat.x), 64'd719);
    chk("clamp720_last_fx", 64'(last_beat.fx), 64'd76);
    push_model(1024, 1, 700, 4, 180, 256);
    start_frame(1024, 1, 700, 4, 180, 256);
    wait_done(1100, 1'b0, "clamp700");
    chk("clamp700_last_x", 64'(last_beat.x), 64'd699);
    chk("clamp700_last_fx", 64'(last_beat.fx), 64'd0);

    // Same frame with full throughput then under backpressure
    push_model(6, 3, 6, 3, 200, 300);
    start_frame(6, 3, 6, 3, 200, 300);
    wait_done(100, 1'b0, "bp_ref");
    push_model(6, 3, 6, 3, 200, 300);
    start_frame(6, 3, 6, 3, 200, 300);
    wait_done(400, 1'b1, "bp_rand");

    // Input change mid-frame has no effect until the next frame_start
    for (int x = 0; x < 4; x++) push_b(x, 0, 0, 0, x == 3, x == 3);
    start_frame(4, 1, 8, 1, 256, 256);
    @(posedge clk_wr); #1;
    h_scale_k = KW'(329);
    t_width   = DW'(2);
    wait_done(40, 1'b0, "param_hold");
    push_b(0, 0, 0,   0, 1'b0, 1'b0);
    push_b(1, 0, 73,  0, 1'b0, 1'b0);
    push_b(2, 0, 146, 0, 1'b0, 1'b0);
    push_b(3, 0, 219, 0, 1'b1, 1'b1);
    start_frame(4, 1, 8, 1, 329, 256);
    wait_done(40, 1'b0, "param_new");

    // Abort while beat 5 of 8 is pending, then a full restarted frame
    d0 = n_done; e0 = n_err;
    for (int x = 0; x < 4; x++) push_b(x, 0, 0, 0, 1'b0, 1'b0);
    for (int x = 0; x < 8; x++) push_b(x, 0, 0, 0, x == 7, x == 7);
    start_frame(8, 1, 8, 1, 256, 256);
    repeat (5) @(posedge clk_wr);
    #1;
    frame_start = 1'b1;
    @(posedge clk_wr); #1;
    frame_start = 1'b0;
    chk("abort_restart_err", 64'(restart_err), 64'd1);
    chk("abort_valid_in_load", 64'(coord_valid), 64'd0);
    wait_done(40, 1'b0, "abort");
    chk("abort_err_cnt", 64'(n_err - e0), 64'd1);
    chk("abort_done_cnt", 64'(n_done - d0), 64'd1);

    // Zero height: frame_done with no beats
    d0 = n_done; b0 = n_beats;
    start_frame(4, 0, 4, 4, 256, 256);
    wait_done(10, 1'b0, "zero_h");
    chk("zero_h_beats", 64'(n_beats - b0), 64'd0);
    chk("zero_h_done_cnt", 64'(n_done - d0), 64'd1);

    // Reset in the middle of a frame
    push_model(8, 1, 8, 1, 300, 256);
    start_frame(8, 1, 8, 1, 300, 256);
    repeat (3) @(posedge clk_wr);
    #1;
    chk("midrst_pre_valid", 64'(coord_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk_wr); #1;
    chk("midrst_valid", 64'(coord_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fields", 64'(cur_beat()), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk_wr); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scale_coord_gen.md
Name: scale_coord_gen

Overview:
- Target-raster coordinate generator for the video scaler datapath.
- Runs in the write clock domain and consumes the per-frame scale parameters produced by the parameter-switch stage: t_width/t_height and h_scale_k/v_scale_k, where k = source*256/target.
- For every target pixel it emits the source integer coordinate and the 8-bit interpolation fraction, under a valid/ready handshake.
- The downstream line-buffer/interpolator consumes these coordinates.

Parameters:
- DW, 11, width of dimension and coordinate fields.
- KW, 16, width of scale factors.
- FRAC, 8, fraction bits in scale factors (k=256 means 1:1).

Ports:
- clk_wr  in  1  write-domain pixel clock.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at start of a target frame (registered vsync edge).
- t_width  in  DW  target width, pixels.
- t_height  in  DW  target height, lines.
- s_width  in  DW  source width, used for clamping.
- s_height  in  DW  source height, used for clamping.
- h_scale_k  in  KW  horizontal step, Q8.8.
- v_scale_k  in  KW  vertical step, Q8.8.
- coord_ready  in  1  downstream accepts the current beat.
- coord_valid  out  1  beat valid.
- src_x  out  DW  source column, clamped.
- src_y  out  DW  source row, clamped.
- frac_x  out  FRAC  horizontal fraction.
- frac_y  out  FRAC  vertical fraction.
- line_last  out  1  last beat of a target line.
- frame_last  out  1  last beat of the frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- restart_err  out  1  one-cycle pulse when frame_start aborts a running frame.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0.
- FSM states:
  - IDLE -> LOAD on frame_start.
  - LOAD -> RUN when the latched t_width != 0 and t_height != 0; otherwise LOAD -> IDLE with a frame_done pulse and no beats.
  - RUN -> DONE when the frame_last beat is accepted.
  - DONE -> IDLE after one cycle; frame_done = 1 in DONE.
- LOAD:
  - Shadow-registers t_width, t_height, s_width, s_height, h_scale_k and v_scale_k.
  - Input changes after LOAD have no effect until the next frame_start.
  - Clears acc_x and acc_y, and clears the target counters tx and ty.
- Latency: frame_start at cycle N -> LOAD at N+1 -> first coord_valid at N+2.
- Accumulators (27 bits = DW+KW):
  - acc_x resets to 0 at each line start and adds h_scale_k on each accepted beat.
  - acc_y adds v_scale_k on each accepted line_last beat.
- Output mapping:
  - src_x = min(acc_x >> 8, s_width-1), frac_x = acc_x[7:0].
  - When clamping occurs, frac_x is forced to 0.
  - The y axis follows the same rules with acc_y and s_height.
  - A latched s_width or s_height of 0 clamps to 0.
- Handshake:
  - All outputs are registered.
  - While coord_valid && !coord_ready, every output field holds stable.
  - coord_valid stays high continuously in RUN and drops only in DONE or IDLE.
  - No beat is dropped or duplicated.
- line_last = (tx == t_width-1). frame_last = line_last && (ty == t_height-1).
- frame_start during RUN or DONE:
  - Abort the current frame: no frame_done, pulse restart_err, go to LOAD.
  - The beat pending at that edge is withdrawn; coord_valid = 0 in LOAD.
- frame_start in the same cycle as the final accepted beat counts as a restart; restart_err is asserted.
- rst mid-frame: returns to IDLE on the next edge with all outputs cleared.
- Counters tx and ty are DW bits wide; the maximum of 2047 needs no wrap handling because the limits are latched.

Decomposition:
- Package scale_pkg holds:
  - DW, KW, FRAC, and ACCW = DW+KW.
  - FSM state encoding: IDLE, LOAD, RUN, DONE.
  - K_UNITY = 256.
- One sub-module, scale_axis_acc, is instantiated twice (x and y):
  - Inputs: clr, step enable, k, src limit.
  - Outputs: accumulator, clamped integer, fraction.

Test Plan:
- 1:1 mapping: s=4x2, t=4x2, k=256/256, coord_ready=1 -> beats (0,0)..(3,0),(0,1)..(3,1); all frac 0; line_last on beats 4 and 8; frame_last on beat 8; frame_done 1 cycle later; first valid at frame_start+2.
- Upscale: s_width=2, t_width=4, h_scale_k=128 -> src_x 0,0,1,1 and frac_x 0,128,0,128.
- Clamp, production parameters: s=720x?, t_width=1024, h_scale_k=180 -> tx=1023 gives src_x 719 and frac_x 76. Then force s_width=700 -> src_x 699, frac_x 0.
- Backpressure: toggle coord_ready randomly, plus a 10-cycle stall mid-line -> outputs stable while stalled; beat sequence identical to the coord_ready=1 run.
- Parameter change mid-frame: change h_scale_k 256->329 during RUN -> no effect on the current frame; takes effect after the next frame_start.
- Abort and zero dimensions:
  - frame_start at beat 5 of an 8-beat frame -> restart_err pulse, no frame_done, beat sequence restarts at (0,0).
  - t_height=0 -> frame_done with zero beats.
